// File: rtl/acc_pkg.sv
// Constants shared by the multiplier row feeder and the column-sum accumulator.
package acc_pkg;

  localparam logic [1:0] CONV = 2'b01;
  localparam logic [1:0] SUB  = 2'b10;

  localparam int K_CONV = 5;
  localparam int K_SUB  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic mode_ok(input logic [1:0] mode);
    return (mode == CONV) || (mode == SUB);
  endfunction

  // Index of the last kernel row used by a pass in the given mode.
  function automatic logic [2:0] last_row(input logic [1:0] mode);
    return (mode == SUB) ? 3'(K_SUB - 1) : 3'(K_CONV - 1);
  endfunction

endpackage

// File: rtl/skew_delay.sv
// Fixed-depth shift register; DEPTH=0 degenerates to a wire.
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_d
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign o_d = i_d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = i_d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign o_d = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mul_row_feeder.sv
// Kernel-row multiplier feeding the column-sum accumulator with column-skewed products.
module mul_row_feeder
  import acc_pkg::*;
#(
  parameter int COLS = 5,
  parameter int I_BW = 8,
  parameter int W_BW = 8,
  parameter int M_BW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           i_mode,
  input  logic [7:0]           i_num_win,
  input  logic                 i_start,
  input  logic                 i_w_we,
  input  logic [2:0]           i_w_row,
  input  logic [W_BW*COLS-1:0] i_w_data,
  input  logic                 i_act_valid,
  output logic                 o_act_ready,
  input  logic [I_BW*COLS-1:0] i_act_data,
  output logic [1:0]           o_mul_loop,
  output logic [M_BW*COLS-1:0] o_mul_result,
  output logic [2:0]           o_row_idx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int DR_W = $clog2(COLS + 2);

  logic [1:0]           state_q, state_d, mode_q, mode_d, loop_q, loop_d;
  logic [7:0]           win_q, win_d;
  logic [2:0]           row_q, row_d;
  logic [DR_W-1:0]      drain_q, drain_d;
  logic                 ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [W_BW-1:0]      w_q [COLS][COLS];
  logic [W_BW-1:0]      w_d [COLS][COLS];
  logic [M_BW*COLS-1:0] prod_q, prod_d, skew_s, result_q, result_d;
  logic                 accept_s;

  assign accept_s = i_act_valid & ready_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    win_d   = win_q;
    row_d   = row_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    w_d     = w_q;
    prod_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_w_we && (i_w_row < 3'(COLS))) begin
          for (int c = 0; c < COLS; c++) begin
            w_d[i_w_row][c] = i_w_data[c*W_BW +: W_BW];
          end
        end else begin
          w_d = w_q;
        end
        if (i_start && mode_ok(i_mode)) begin
          if (i_num_win != 8'd0) begin
            state_d = ST_RUN;
            mode_d  = i_mode;
            win_d   = i_num_win;
            row_d   = 3'd0;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          if (row_q == last_row(mode_q)) begin
            row_d = 3'd0;
            win_d = win_q - 8'd1;
            if (win_q == 8'd1) begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      // Hold off new rows until the deepest skew column has flushed.
      ST_DRAIN: begin
        if (drain_q == DR_W'(COLS)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + {{(DR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Idle cycles push zero products so the accumulator chain stays aligned.
    for (int c = 0; c < COLS; c++) begin
      if (accept_s && !((mode_q == SUB) && (c == COLS - 1))) begin
        prod_d[c*M_BW +: M_BW] = M_BW'(i_act_data[c*I_BW +: I_BW]) * M_BW'(w_q[row_q][c]);
      end else begin
        prod_d[c*M_BW +: M_BW] = '0;
      end
    end

    ready_d  = (state_d == ST_RUN);
    busy_d   = (state_d != ST_IDLE);
    loop_d   = busy_d ? mode_d : 2'b00;
    result_d = skew_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= 2'b00;
      loop_q   <= 2'b00;
      win_q    <= 8'd0;
      row_q    <= 3'd0;
      drain_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
      result_q <= '0;
      for (int r = 0; r < COLS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          w_q[r][c] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      loop_q   <= loop_d;
      win_q    <= win_d;
      row_q    <= row_d;
      drain_q  <= drain_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      w_q      <= w_d;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    skew_delay #(
      .DEPTH(c),
      .WIDTH(M_BW)
    ) u_skew (
      .clk(clk),
      .rst(rst),
      .i_d(prod_q[c*M_BW +: M_BW]),
      .o_d(skew_s[c*M_BW +: M_BW])
    );
  end

  assign o_act_ready  = ready_q;
  assign o_mul_loop   = loop_q;
  assign o_mul_result = result_q;
  assign o_row_idx    = row_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_mul_row_feeder.sv
// Bench for mul_row_feeder: table-driven passes plus hand sequences, checked by a skew scoreboard.
module tb_mul_row_feeder;

  logic        clk, rst;
  logic [1:0]  i_mode;
  logic [7:0]  i_num_win;
  logic        i_start, i_w_we, i_act_valid;
  logic [2:0]  i_w_row;
  logic [39:0] i_w_data, i_act_data;
  logic        o_act_ready, o_busy, o_done;
  logic [1:0]  o_mul_loop;
  logic [79:0] o_mul_result;
  logic [2:0]  o_row_idx;

  mul_row_feeder dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_num_win(i_num_win), .i_start(i_start),
    .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_data(i_w_data), .i_act_valid(i_act_valid),
    .o_act_ready(o_act_ready), .i_act_data(i_act_data), .o_mul_loop(o_mul_loop),
    .o_mul_result(o_mul_result), .o_row_idx(o_row_idx), .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  w;
    logic [39:0] act;
    logic [79:0] exp;
  } vec_t;

  int total = 0, bad = 0;
  int cyc = 0;
  // Behavioural model state
  logic [7:0]  mw [5][5];
  logic [79:0] hist[$];
  logic        m_idle, m_ready, m_busy;
  logic [1:0]  m_loop, m_mode;
  int          m_row, m_k, m_left, done_edge, first_acc, last_acc;
  // Observations of the DUT
  int          dut_acc, done_cnt, done_cyc;
  logic [15:0] cap [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) mw[r][c] = 8'd0;
    hist.delete();
    for (int i = 0; i < 6; i++) hist.push_front(80'd0);
    m_idle = 1'b1; m_ready = 1'b0; m_busy = 1'b0; m_loop = 2'b00; m_mode = 2'b00;
    m_row = 0; m_k = 5; m_left = 0; done_edge = -1;
  endtask

  task automatic model_update();
    logic [79:0] vec;
    logic acc, pre_idle;
    cyc++;
    acc = i_act_valid && m_ready;
    vec = 80'd0;
    if (acc) begin
      for (int c = 0; c < 5; c++)
        if (!(m_mode == 2'b10 && c == 4))
          vec[c*16 +: 16] = 16'(i_act_data[c*8 +: 8]) * 16'(mw[m_row][c]);
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      m_row = (m_row + 1) % m_k;
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b0;
        done_edge = cyc + 6;
      end
    end
    hist.push_front(vec);
    if (hist.size() > 6) void'(hist.pop_back());
    pre_idle = m_idle;
    if (!pre_idle && cyc == done_edge) begin
      m_idle = 1'b1; m_busy = 1'b0; m_loop = 2'b00;
    end
    if (pre_idle) begin
      if (i_w_we && i_w_row < 3'd5)
        for (int c = 0; c < 5; c++) mw[i_w_row][c] = i_w_data[c*8 +: 8];
      if (i_start && (i_mode == 2'b01 || i_mode == 2'b10)) begin
        if (i_num_win == 8'd0) begin
          done_edge = cyc;
        end else begin
          m_idle = 1'b0; m_busy = 1'b1; m_ready = 1'b1; m_loop = i_mode; m_mode = i_mode;
          m_k = (i_mode == 2'b01) ? 5 : 4;
          m_left = m_k * int'(i_num_win);
          m_row = 0;
        end
      end
    end
  endtask

  task automatic compare();
    logic [79:0] hv;
    check("ready", 32'(o_act_ready), 32'(m_ready));
    check("busy", 32'(o_busy), 32'(m_busy));
    check("loop", 32'(o_mul_loop), 32'(m_loop));
    check("done", 32'(o_done), 32'(cyc == done_edge));
    check("row_idx", 32'(o_row_idx), 32'(m_row));
    for (int c = 0; c < 5; c++) begin
      hv = hist[1+c];
      check($sformatf("col%0d", c), 32'(o_mul_result[c*16 +: 16]), 32'(hv[c*16 +: 16]));
      if (first_acc >= 0 && cyc == first_acc + 1 + c) cap[c] = o_mul_result[c*16 +: 16];
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic step();
    if (i_act_valid && o_act_ready) dut_acc++;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic run_pass(input logic [1:0] mode, input int nw, input logic [39:0] act,
                          input int prob, input bit rnd, input bit we_run);
    first_acc = -1; dut_acc = 0; done_cnt = 0;
    i_mode = mode; i_num_win = 8'(nw); i_start = 1'b1;
    step();
    i_start = 1'b0; i_w_we = 1'b0;
    for (int k = 0; k < 300 && !m_idle; k++) begin
      i_act_valid = ($urandom_range(99) < prob);
      i_act_data  = rnd ? 40'({$urandom(), $urandom()}) : act;
      if (we_run) begin
        i_w_we = 1'b1; i_w_row = 3'($urandom_range(4)); i_w_data = 40'({$urandom(), $urandom()});
      end
      step();
    end
    check("pass_end", 32'(o_busy), 32'd0);
    i_act_valid = 1'b0; i_w_we = 1'b0;
    step();
    step();
  endtask

  task automatic write_all(input logic [7:0] w);
    for (int r = 0; r < 5; r++) begin
      i_w_we = 1'b1; i_w_row = 3'(r); i_w_data = {5{w}};
      step();
    end
    i_w_we = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [5];
    tbl[0] = '{2'b01, 8'd2,   {8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
               {16'd10, 16'd8, 16'd6, 16'd4, 16'd2}};
    tbl[1] = '{2'b10, 8'd3,   {5{8'd4}}, {16'd0, 16'd12, 16'd12, 16'd12, 16'd12}};
    tbl[2] = '{2'b01, 8'd255, {5{8'd255}}, {5{16'd65025}}};
    tbl[3] = '{2'b10, 8'd255, {5{8'd255}}, {16'd0, {4{16'd65025}}}};
    tbl[4] = '{2'b01, 8'd7,   {8'd200, 8'd100, 8'd10, 8'd1, 8'd0},
               {16'd1400, 16'd700, 16'd70, 16'd7, 16'd0}};

    rst = 1'b1; i_mode = 2'b00; i_num_win = 8'd0; i_start = 1'b0; i_w_we = 1'b0;
    i_w_row = 3'd0; i_w_data = 40'd0; i_act_valid = 1'b0; i_act_data = 40'd0;
    first_acc = -1; last_acc = 0; dut_acc = 0; done_cnt = 0; done_cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_result", o_mul_result[31:0], 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      write_all(tbl[i].w);
      run_pass(tbl[i].mode, 1, tbl[i].act, 100, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++)
        check($sformatf("tbl%0d_col%0d", i, c), 32'(cap[c]), 32'(tbl[i].exp[c*16 +: 16]));
      check("tbl_accepts", 32'(dut_acc), (tbl[i].mode == 2'b01) ? 32'd5 : 32'd4);
      check("tbl_done_lat", 32'(done_cyc - last_acc), 32'd6);
    end

    // Two CONV windows with random valid gaps
    for (int r = 0; r < 5; r++) begin
      i_w_we = 1'b1; i_w_row = 3'(r); i_w_data = 40'({$urandom(), $urandom()});
      step();
    end
    i_w_we = 1'b0;
    run_pass(2'b01, 2, 40'd0, 60, 1'b1, 1'b0);
    check("multi_accepts", 32'(dut_acc), 32'd10);
    check("multi_done_cnt", 32'(done_cnt), 32'd1);

    // Invalid modes are ignored
    done_cnt = 0;
    i_mode = 2'b00; i_num_win = 8'd3; i_start = 1'b1;
    step();
    i_mode = 2'b11;
    step();
    i_start = 1'b0;
    repeat (4) step();
    check("mode_bad_busy", 32'(o_busy), 32'd0);
    check("mode_bad_done", 32'(done_cnt), 32'd0);

    // Zero windows gives only a done pulse
    run_pass(2'b10, 0, 40'd0, 100, 1'b1, 1'b0);
    check("nw0_done_cnt", 32'(done_cnt), 32'd1);

    // Weight writes during a pass are ignored
    run_pass(2'b01, 1, 40'd0, 100, 1'b1, 1'b1);

    // Row 6 write is ignored
    i_w_we = 1'b1; i_w_row = 3'd6; i_w_data = {5{8'hff}};
    step();
    i_w_we = 1'b0;
    run_pass(2'b01, 1, 40'd0, 100, 1'b1, 1'b0);

    // Write together with start commits and is used
    i_w_we = 1'b1; i_w_row = 3'd2; i_w_data = 40'({$urandom(), $urandom()});
    run_pass(2'b10, 1, 40'd0, 100, 1'b1, 1'b0);

    // Reset in the middle of a pass
    i_mode = 2'b01; i_num_win = 8'd2; i_start = 1'b1;
    step();
    i_start = 1'b0; i_act_valid = 1'b1; i_act_data = {5{8'd9}};
    repeat (4) step();
    done_cnt = 0;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_ready", 32'(o_act_ready), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_loop", 32'(o_mul_loop), 32'd0);
    check("mid_rst_row", 32'(o_row_idx), 32'd0);
    check("mid_rst_res_lo", o_mul_result[31:0], 32'd0);
    check("mid_rst_res_hi", 32'(o_mul_result[79:32]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; i_act_valid = 1'b0;
    step();
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    run_pass(2'b01, 1, 40'd0, 100, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
